// File: rtl/dram_cmd_arbiter.sv
// Two-port round-robin arbiter and single-outstanding command sequencer for the
// LPDDR4 dummy memory model: fetch port 0 (read-only), load/store port 1.
module dram_cmd_arbiter #(
  parameter int                MEM_AW   = 14,
  parameter int                DATA_W   = 32,
  parameter logic [2:0]        BANK     = 3'd0,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [31:0]           p0_req_addr,
  output logic                  p0_rsp_valid,
  output logic [DATA_W-1:0]     p0_rsp_rdata,
  output logic                  p0_rsp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [31:0]           p1_req_addr,
  input  logic [DATA_W-1:0]     p1_req_wdata,
  input  logic [DATA_W/8-1:0]   p1_req_wstrb,
  output logic                  p1_rsp_valid,
  output logic [DATA_W-1:0]     p1_rsp_rdata,
  output logic                  p1_rsp_err,
  output logic                  mem_cs_n,
  output logic                  mem_ras_n,
  output logic                  mem_cas_n,
  output logic                  mem_we_n,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [2:0]            mem_ba,
  output logic [DATA_W-1:0]     mem_dq_out,
  output logic                  mem_dq_oe,
  input  logic [DATA_W-1:0]     mem_dq_in,
  output logic [DATA_W/8-1:0]   mem_dm,
  output logic                  mem_dqs
);

  // Handshake: a request transfers on a rising edge where valid && ready.
  // Ready is only ever raised in IDLE, for the arbitration winner; requesters
  // hold valid and payload until then. Responses are single-cycle pulses with
  // no back-pressure.
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RDWAIT, ST_RESP} state_t;

  state_t              state, state_d;
  logic                last_grant, lat_port, lat_we;
  logic                gnt_p0, gnt_p1, accept, sel_p1, sel_we, sel_oor;
  logic [31:0]         sel_addr;
  logic                rsp_set, rsp_port, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data;

  assign mem_ba = BANK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
    accept       = 1'b0;
    rsp_set      = 1'b0;
    rsp_port     = lat_port;
    rsp_data     = '0;
    rsp_err_d    = 1'b0;
    // On a tie the port that was not granted last time wins.
    gnt_p0   = p0_req_valid && (!p1_req_valid || last_grant);
    gnt_p1   = p1_req_valid && (!p0_req_valid || !last_grant);
    sel_p1   = gnt_p1;
    sel_addr = sel_p1 ? p1_req_addr : p0_req_addr;
    sel_we   = sel_p1 && p1_req_we;
    sel_oor  = (sel_addr >> MEM_AW) != 32'd0;
    case (state)
      ST_IDLE: begin
        p0_req_ready = gnt_p0;
        p1_req_ready = gnt_p1;
        accept       = gnt_p0 || gnt_p1;
        if (accept) begin
          if (sel_oor) begin
            state_d   = ST_RESP;
            rsp_set   = 1'b1;
            rsp_port  = sel_p1;
            rsp_data  = ERR_DATA;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (lat_we) begin
          state_d = ST_RESP;
          rsp_set = 1'b1;
        end else begin
          state_d = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        state_d  = ST_RESP;
        rsp_set  = 1'b1;
        rsp_data = mem_dq_in;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command pins are loaded on the acceptance edge so they are valid for
  // exactly the CMD cycle, then fall back to idle by default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= 1'b1;
      lat_port     <= 1'b0;
      lat_we       <= 1'b0;
      mem_cs_n     <= 1'b1;
      mem_ras_n    <= 1'b1;
      mem_cas_n    <= 1'b1;
      mem_we_n     <= 1'b1;
      mem_addr     <= '0;
      mem_dq_out   <= '0;
      mem_dq_oe    <= 1'b0;
      mem_dm       <= '0;
      mem_dqs      <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_rdata <= '0;
      p1_rsp_err   <= 1'b0;
    end else begin
      mem_cs_n     <= 1'b1;
      mem_ras_n    <= 1'b1;
      mem_cas_n    <= 1'b1;
      mem_we_n     <= 1'b1;
      mem_dq_oe    <= 1'b0;
      mem_dm       <= '0;
      mem_dqs      <= 1'b0;
      p0_rsp_valid <= rsp_set && !rsp_port;
      p1_rsp_valid <= rsp_set && rsp_port;
      if (rsp_set && !rsp_port) begin
        p0_rsp_rdata <= rsp_data;
        p0_rsp_err   <= rsp_err_d;
      end
      if (rsp_set && rsp_port) begin
        p1_rsp_rdata <= rsp_data;
        p1_rsp_err   <= rsp_err_d;
      end
      if (accept) begin
        last_grant <= sel_p1;
        lat_port   <= sel_p1;
        lat_we     <= sel_we;
        if (!sel_oor) begin
          mem_cs_n  <= 1'b0;
          mem_ras_n <= 1'b0;
          mem_cas_n <= 1'b0;
          mem_we_n  <= !sel_we;
          mem_addr  <= sel_addr[MEM_AW-1:0];
          if (sel_we) begin
            mem_dq_oe  <= 1'b1;
            mem_dq_out <= p1_req_wdata;
            mem_dm     <= ~p1_req_wstrb;
            mem_dqs    <= 1'b1;
          end
        end
      end
    end
  end

endmodule
